// File: rtl/trigger_sched_pkg.sv
// Shared types for the camera-trigger sequencer: FSM states and the captured event record.
package trigger_sched_pkg;

    localparam int unsigned SEQ_W = 16;
    localparam int unsigned EV_W  = 64 + SEQ_W;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [63:0]      ts;
    } ev_t;

endpackage

// File: rtl/trig_event_fifo.sv
// First-word-fall-through synchronous FIFO holding captured trigger events.
module trig_event_fifo #(
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full is still accepted.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trigger_scheduler.sv
// Periodic camera-trigger sequencer on usec timestamp boundaries with event capture FIFO.
// Optional one-shot software trigger port enabled by defining TRIG_SW_EN.
module trigger_scheduler
    import trigger_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned PULSE_W  = 16,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic                clk125,
    input  logic                rst_n,
    input  logic [63:0]         ts,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period_us,
    input  logic [PULSE_W-1:0]  pulse_us,
`ifdef TRIG_SW_EN
    input  logic                sw_trig,
`endif
    output logic                trig_out,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [63:0]         ev_ts,
    output logic [SEQ_W-1:0]    ev_seq,
    output logic                ev_ovf,
    input  logic                ev_ovf_clr,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [63:0]         ts_q;
    logic                primed_q;
    logic                tick;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d, period_c;
    logic [PERIOD_W-1:0] pulse_q, pulse_d, pulse_c;
    logic [SEQ_W-1:0]    seq_q;
    logic                trig_q;
    logic                ovf_q;
    logic                capture;
    logic                sw_go;
    logic                fifo_full, fifo_empty, fifo_pop, drop;
    ev_t                 ev_in, ev_head;

    // Suppress the tick on the first cycle out of reset while ts_q primes.
    assign tick = primed_q && (ts != ts_q);

`ifdef TRIG_SW_EN
    logic sw_pend_q;

    // Hold a software request seen in IDLE until the next usec boundary starts the pulse.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) sw_pend_q <= 1'b0;
        else        sw_pend_q <= (state_q == IDLE) && !capture && (sw_pend_q || sw_trig);
    end
    assign sw_go = sw_pend_q || (sw_trig && (state_q == IDLE));
`else
    assign sw_go = 1'b0;
`endif

    always_comb begin
        period_c = period_us;
        if (period_us < PERIOD_W'(2)) period_c = PERIOD_W'(2);
        pulse_c = PERIOD_W'(pulse_us);
        if (pulse_c == '0) pulse_c = PERIOD_W'(1);
        if (pulse_c >= period_c) pulse_c = period_c - PERIOD_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pulse_d  = pulse_q;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && (en || sw_go)) begin
                    state_d  = PULSE;
                    cnt_d    = '0;
                    period_d = period_c;
                    pulse_d  = pulse_c;
                    capture  = 1'b1;
                end
            end
            PULSE: begin
                if (tick) begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                    if (cnt_q == pulse_q - PERIOD_W'(1)) state_d = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                    if (cnt_q == period_q - PERIOD_W'(1)) begin
                        if (en) begin
                            state_d  = PULSE;
                            cnt_d    = '0;
                            period_d = period_c;
                            pulse_d  = pulse_c;
                            capture  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ts_q     <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            period_q <= PERIOD_W'(2);
            pulse_q  <= PERIOD_W'(1);
            seq_q    <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts;
            primed_q <= 1'b1;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
            trig_q   <= (state_d == PULSE);
            if (capture) seq_q <= seq_q + 1'b1;
            if (drop)             ovf_q <= 1'b1;
            else if (ev_ovf_clr)  ovf_q <= 1'b0;
        end
    end

    assign ev_in    = '{seq: seq_q, ts: ts};
    assign fifo_pop = ev_ready && !fifo_empty;
    assign drop     = capture && fifo_full && !fifo_pop;

    trig_event_fifo #(
        .AW    (FIFO_AW),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk   (clk125),
        .rst_n (rst_n),
        .push  (capture),
        .wdata (ev_in),
        .pop   (fifo_pop),
        .rdata (ev_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trig_out = trig_q;
    assign ev_valid = !fifo_empty;
    assign ev_ts    = fifo_empty ? 64'd0 : ev_head.ts;
    assign ev_seq   = fifo_empty ? '0 : ev_head.seq;
    assign ev_ovf   = ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed bench for trigger_scheduler: timing, en drop, overflow, clamps, same-cycle pop/push, reset.
module tb_trigger_scheduler;
    import trigger_sched_pkg::*;

    logic             clk125 = 1'b0;
    logic             rst_n = 1'b0;
    logic [63:0]      ts = 64'd100;
    logic             en = 1'b0;
    logic [23:0]      period_us = 24'd10;
    logic [15:0]      pulse_us = 16'd3;
    logic             ev_ready = 1'b0;
    logic             ev_ovf_clr = 1'b0;
    logic             trig_out, ev_valid, ev_ovf, busy;
    logic [63:0]      ev_ts;
    logic [SEQ_W-1:0] ev_seq;
`ifdef TRIG_SW_EN
    logic             sw_trig = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] base, tb_b, tb_c;

    always #4 clk125 = ~clk125;

    trigger_scheduler dut (
        .clk125     (clk125),
        .rst_n      (rst_n),
        .ts         (ts),
        .en         (en),
        .period_us  (period_us),
        .pulse_us   (pulse_us),
`ifdef TRIG_SW_EN
        .sw_trig    (sw_trig),
`endif
        .trig_out   (trig_out),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_ts      (ev_ts),
        .ev_seq     (ev_seq),
        .ev_ovf     (ev_ovf),
        .ev_ovf_clr (ev_ovf_clr),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the timestamp by one usec; returns 1 ns after a clock edge.
    task automatic step();
        ts = ts + 64'd1;
        repeat (125) @(posedge clk125);
        #1;
    endtask

    task automatic pop_chk(input string tag, input int exp_seq, input logic [63:0] exp_ts);
        chk({tag, "_valid"}, 64'(ev_valid), 64'd1);
        chk({tag, "_seq"}, 64'(ev_seq), 64'(exp_seq));
        chk({tag, "_ts"}, ev_ts, exp_ts);
        ev_ready = 1'b1;
        @(posedge clk125);
        #1;
        ev_ready = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk125);
        #1;
        rst_n = 1'b1;
        @(posedge clk125);
        #1;
    endtask

    initial begin
        // Reset state, with en already high and ts non-zero across release
        en = 1'b1;
        repeat (3) @(posedge clk125);
        #1;
        chk("rst_trig", 64'(trig_out), 64'd0);
        chk("rst_valid", 64'(ev_valid), 64'd0);
        chk("rst_ovf", 64'(ev_ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ev_ts", ev_ts, 64'd0);
        chk("rst_ev_seq", 64'(ev_seq), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk125);
        #1;
        chk("first_tick_suppressed", 64'(busy), 64'd0);

        // 1: period 10, pulse 3
        base = ts + 64'd1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 10; k++) begin
                step();
                chk($sformatf("t1_trig_p%0d_k%0d", p, k), 64'(trig_out), 64'(k < 3));
            end
        end
        chk("t1_busy", 64'(busy), 64'd1);

        // 2: en dropped one usec into the pulse
        step();
        chk("t2_rise", 64'(trig_out), 64'd1);
        step();
        en = 1'b0;
        step();
        chk("t2_still_high", 64'(trig_out), 64'd1);
        step();
        chk("t2_low", 64'(trig_out), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("t2_wait_busy_%0d", k), 64'(busy), 64'd1);
            chk($sformatf("t2_wait_trig_%0d", k), 64'(trig_out), 64'd0);
        end
        step();
        chk("t2_idle_busy", 64'(busy), 64'd0);
        step();
        step();
        chk("t2_no_rise", 64'(trig_out), 64'd0);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("t12_ev%0d", i), i, base + 64'(10 * i));
        chk("t12_empty", 64'(ev_valid), 64'd0);

        // 3: overflow with ev_ready held low, period 2 / pulse 1
        do_reset();
        chk("t3_rst_seq", 64'(ev_seq), 64'd0);
        period_us = 24'd2;
        pulse_us = 16'd1;
        en = 1'b1;
        base = ts + 64'd1;
        for (int i = 0; i < 21; i++) begin
            step();
            if (i == 18) en = 1'b0;
            chk($sformatf("t3_trig_%0d", i), 64'(trig_out), 64'((i % 2 == 0) && (i <= 18)));
        end
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_ovf", 64'(ev_ovf), 64'd1);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("t3_ev%0d", i), i, base + 64'(2 * i));
        chk("t3_empty", 64'(ev_valid), 64'd0);
        chk("t3_ovf_sticky", 64'(ev_ovf), 64'd1);
        ev_ovf_clr = 1'b1;
        @(posedge clk125);
        #1;
        ev_ovf_clr = 1'b0;
        chk("t3_ovf_clr", 64'(ev_ovf), 64'd0);
        en = 1'b1;
        step();
        en = 1'b0;
        chk("t3_next_seq", 64'(ev_seq), 64'd10);
        step();
        step();
        pop_chk("t3_ev10", 10, ts - 64'd2);

        // 4: clamps, then config change applied at the next rising edge
        period_us = 24'd1;
        pulse_us = 16'd0;
        en = 1'b1;
        base = ts + 64'd1;
        step();
        chk("t4_a_hi", 64'(trig_out), 64'd1);
        step();
        chk("t4_a_lo", 64'(trig_out), 64'd0);
        period_us = 24'd5;
        pulse_us = 16'd20;
        tb_b = ts + 64'd1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t4_b_%0d", k), 64'(trig_out), 64'(k < 4));
        end
        tb_c = ts + 64'd1;
        step();
        chk("t4_c_rise", 64'(trig_out), 64'd1);
        en = 1'b0;
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("t4_c_%0d", k), 64'(trig_out), 64'(k < 4));
        end
        chk("t4_c_busy", 64'(busy), 64'd1);
        step();
        chk("t4_c_idle", 64'(busy), 64'd0);
        pop_chk("t4_ev_a", 11, base);
        pop_chk("t4_ev_b", 12, tb_b);
        pop_chk("t4_ev_c", 13, tb_c);
        chk("t4_empty", 64'(ev_valid), 64'd0);

        // 5: full FIFO with pop and push in the same cycle
        do_reset();
        period_us = 24'd2;
        pulse_us = 16'd1;
        en = 1'b1;
        base = ts + 64'd1;
        for (int i = 0; i < 16; i++) step();
        ts = ts + 64'd1;
        ev_ready = 1'b1;
        @(posedge clk125);
        #1;
        ev_ready = 1'b0;
        repeat (124) @(posedge clk125);
        #1;
        en = 1'b0;
        chk("t5_rise", 64'(trig_out), 64'd1);
        step();
        step();
        chk("t5_ovf", 64'(ev_ovf), 64'd0);
        for (int i = 1; i < 9; i++) pop_chk($sformatf("t5_ev%0d", i), i, base + 64'(2 * i));
        chk("t5_empty", 64'(ev_valid), 64'd0);

`ifdef TRIG_SW_EN
        // 6a: one-shot software trigger
        period_us = 24'd3;
        pulse_us = 16'd1;
        sw_trig = 1'b1;
        @(posedge clk125);
        #1;
        sw_trig = 1'b0;
        base = ts + 64'd1;
        step();
        chk("t6_sw_hi", 64'(trig_out), 64'd1);
        step();
        chk("t6_sw_lo", 64'(trig_out), 64'd0);
        step();
        chk("t6_sw_busy", 64'(busy), 64'd1);
        step();
        chk("t6_sw_idle", 64'(busy), 64'd0);
        step();
        chk("t6_sw_no_repeat", 64'(trig_out), 64'd0);
        pop_chk("t6_sw_ev", 9, base);
        chk("t6_sw_empty", 64'(ev_valid), 64'd0);
`endif

        // 6b: asynchronous reset mid-pulse
        period_us = 24'd10;
        pulse_us = 16'd3;
        en = 1'b1;
        step();
        chk("t6_pre_trig", 64'(trig_out), 64'd1);
        chk("t6_pre_valid", 64'(ev_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_trig", 64'(trig_out), 64'd0);
        chk("t6_rst_valid", 64'(ev_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        en = 1'b0;
        @(posedge clk125);
        #1;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
